pwm_ramp_controller: RTL and testbench

Soft-start and slew-rate controller that sequences the 8-bit duty input of the traction PWM generator for one motor.
- Moves the duty toward a commanded target at a fixed rate, never overshooting.
- On a direction reversal, ramps to zero, waits a dead time, then flips the direction line.
- Provides an emergency stop that forces duty to zero on the next clock.
- Sits between the motion command logic and one PWM generator / H-bridge direction pin.

---
 rtl/pwm_ramp_controller_pkg.sv | 20 ++
 rtl/pwm_ramp_controller_tick.sv | 27 ++
 rtl/pwm_ramp_controller.sv | 130 +++++++++++++
 tb/tb_pwm_ramp_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_controller_pkg.sv
// Shared definitions for the traction duty ramp: duty width, clamp ceiling and ramp state encoding.
// The PWM generator and any multi-motor arbiter use the same width and clamp.
package pwm_ramp_controller_pkg;

    localparam int DUTY_W           = 8;
    localparam int DUTY_MAX_DEFAULT = 249;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RAMP = 3'd1,
        HOLD = 3'd2,
        DEAD = 3'd3,
        STOP = 3'd4
    } rampState_t;

    function automatic logic isBusyState(input rampState_t s);
        return (s == RAMP) || (s == DEAD) || (s == STOP);
    endfunction

endpackage

// File: rtl/pwm_ramp_controller_tick.sv
// Free-running ramp tick generator: one-cycle pulse every TICK_DIV clocks,
// with the first pulse seen on the TICK_DIV-th edge after reset.
module ramp_tick_gen #(
    parameter int TICK_DIV = 20000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == CW'(TICK_DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == CW'(TICK_DIV - 1));

endmodule

// File: rtl/pwm_ramp_controller.sv
// Soft-start / slew-rate controller for one traction PWM channel: ramps duty toward a
// clamped target, inserts a dead time around direction reversals, and honours estop.
module pwm_ramp_controller
    import pwm_ramp_controller_pkg::*;
#(
    parameter int STEP           = 1,
    parameter int TICK_DIV       = 20000,
    parameter int DEADTIME_TICKS = 8,
    parameter int DUTY_MAX       = DUTY_MAX_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              target_dir,
    input  logic              estop,
    output logic [DUTY_W-1:0] duty_out,
    output logic              dir_out,
    output logic              busy,
    output logic              at_target
);

    localparam int DW = (DEADTIME_TICKS > 1) ? $clog2(DEADTIME_TICKS) : 1;
    localparam logic [DUTY_W:0] STEP9 = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W:0] MAX9  = (DUTY_W + 1)'(DUTY_MAX);

    rampState_t state, stateNext;
    logic [DW-1:0] deadCnt, deadNext;
    logic [DUTY_W-1:0] dutyNext, stepped;
    logic dirNext, tick, dirMismatch;
    logic [DUTY_W:0] duty9, clamped9, effTarget, gap;

    ramp_tick_gen #(.TICK_DIV(TICK_DIV)) uTick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign dirMismatch = (target_dir != dir_out);
    assign duty9       = {1'b0, duty_out};
    assign clamped9    = ({1'b0, target_duty} > MAX9) ? MAX9 : {1'b0, target_duty};
    assign effTarget   = (!enable || dirMismatch) ? '0 : clamped9;

    // Step is limited to the remaining gap so duty lands exactly on the target.
    always_comb begin
        gap     = '0;
        stepped = duty_out;
        if (duty9 < effTarget) begin
            gap     = effTarget - duty9;
            stepped = DUTY_W'(duty9 + ((gap < STEP9) ? gap : STEP9));
        end else if (duty9 > effTarget) begin
            gap     = duty9 - effTarget;
            stepped = DUTY_W'(duty9 - ((gap < STEP9) ? gap : STEP9));
        end
    end

    always_comb begin
        stateNext = state;
        dutyNext  = duty_out;
        dirNext   = dir_out;
        deadNext  = deadCnt;
        if (estop) begin
            stateNext = STOP;
            dutyNext  = '0;
            deadNext  = '0;
        end else if (tick) begin
            unique case (state)
                IDLE: begin
                    dutyNext = '0;
                    if (enable) begin
                        dirNext   = target_dir;
                        stateNext = RAMP;
                    end
                end
                RAMP: begin
                    dutyNext = stepped;
                    if (stepped == '0 && !enable) begin
                        stateNext = IDLE;
                    end else if (stepped == '0 && dirMismatch) begin
                        stateNext = DEAD;
                        deadNext  = '0;
                    end else if ({1'b0, stepped} == effTarget) begin
                        stateNext = HOLD;
                    end
                end
                HOLD: begin
                    if (effTarget != duty9 || dirMismatch) begin
                        dutyNext  = stepped;
                        stateNext = RAMP;
                    end
                end
                DEAD: begin
                    dutyNext = '0;
                    if (deadCnt == DW'(DEADTIME_TICKS - 1)) begin
                        deadNext  = '0;
                        stateNext = enable ? RAMP : IDLE;
                        if (enable) dirNext = target_dir;
                    end else begin
                        deadNext = deadCnt + DW'(1);
                    end
                end
                STOP: begin
                    // Resuming from estop always passes through the dead time.
                    stateNext = DEAD;
                    deadNext  = '0;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            duty_out  <= '0;
            dir_out   <= 1'b0;
            deadCnt   <= '0;
            busy      <= 1'b0;
            at_target <= 1'b0;
        end else begin
            state     <= stateNext;
            duty_out  <= dutyNext;
            dir_out   <= dirNext;
            deadCnt   <= deadNext;
            busy      <= isBusyState(stateNext);
            at_target <= (stateNext == HOLD);
        end
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed plus randomized bench for pwm_ramp_controller against a cycle-level behavioural model.
module tb_pwm_ramp_controller;

    localparam int TICK_DIV = 4;
    localparam int STEP     = 10;
    localparam int DEADT    = 2;
    localparam int DMAX     = 249;

    localparam int M_IDLE = 0, M_RAMP = 1, M_HOLD = 2, M_DEAD = 3, M_STOP = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] target_duty = 8'd0;
    logic       target_dir = 1'b0;
    logic       estop = 1'b0;
    logic [7:0] duty_out;
    logic       dir_out, busy, at_target;

    int tests = 0;
    int failures = 0;
    int mTick, mMode, mDuty, mDir, mDead;

    pwm_ramp_controller #(
        .STEP(STEP), .TICK_DIV(TICK_DIV), .DEADTIME_TICKS(DEADT), .DUTY_MAX(DMAX)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .target_duty(target_duty),
        .target_dir(target_dir), .estop(estop), .duty_out(duty_out), .dir_out(dir_out),
        .busy(busy), .at_target(at_target)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int toward(input int d, input int e);
        int g;
        g = (d < e) ? e - d : d - e;
        if (g > STEP) g = STEP;
        return (d < e) ? d + g : d - g;
    endfunction

    task automatic modelReset();
        mTick = 0; mMode = M_IDLE; mDuty = 0; mDir = 0; mDead = 0;
    endtask

    // One clock edge of the reference behaviour, from the inputs present before the edge.
    task automatic modelEdge();
        bit tick;
        int eff;
        bit mismatch;
        if (reset) begin
            modelReset();
            return;
        end
        tick  = (mTick == TICK_DIV - 1);
        mTick = (mTick + 1) % TICK_DIV;
        mismatch = (int'(target_dir) != mDir);
        eff = (!enable || mismatch) ? 0 : ((int'(target_duty) > DMAX) ? DMAX : int'(target_duty));
        if (estop) begin
            mMode = M_STOP; mDuty = 0; mDead = 0;
            return;
        end
        if (!tick) return;
        case (mMode)
            M_IDLE: if (enable) begin mDir = int'(target_dir); mMode = M_RAMP; end
            M_RAMP: begin
                mDuty = toward(mDuty, eff);
                if (mDuty == 0 && !enable) mMode = M_IDLE;
                else if (mDuty == 0 && mismatch) begin mMode = M_DEAD; mDead = 0; end
                else if (mDuty == eff) mMode = M_HOLD;
            end
            M_HOLD: if (eff != mDuty || mismatch) begin
                mDuty = toward(mDuty, eff); mMode = M_RAMP;
            end
            M_DEAD: begin
                mDead++;
                if (mDead == DEADT) begin
                    mDead = 0;
                    if (enable) begin mDir = int'(target_dir); mMode = M_RAMP; end
                    else mMode = M_IDLE;
                end
            end
            default: begin mMode = M_DEAD; mDead = 0; end
        endcase
    endtask

    task automatic checkAll();
        chk("duty_out", int'(duty_out), mDuty);
        chk("dir_out", int'(dir_out), mDir);
        chk("busy", int'(busy), int'(mMode == M_RAMP || mMode == M_DEAD || mMode == M_STOP));
        chk("at_target", int'(at_target), int'(mMode == M_HOLD));
    endtask

    task automatic cyc();
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        checkAll();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic runUntilDuty(input int v, input int budget, input string tag);
        int found;
        found = 0;
        for (int i = 0; i < budget && found == 0; i++) begin
            cyc();
            if (mDuty == v && mMode == M_RAMP) found = 1;
        end
        chk(tag, found, 1);
    endtask

    initial begin
        modelReset();
        run(2);
        chk("reset_duty", int'(duty_out), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;

        // 1: soft start to 100
        enable = 1'b1; target_duty = 8'd100; target_dir = 1'b0;
        run(8);
        chk("t1_first_step", int'(duty_out), 10);
        run(40);
        chk("t1_hold_duty", int'(duty_out), 100);
        chk("t1_at_target", int'(at_target), 1);

        // 2: clamp at DUTY_MAX
        target_duty = 8'd240;
        run(64);
        chk("t2_hold240", int'(duty_out), 240);
        target_duty = 8'd255;
        run(12);
        chk("t2_clamp", int'(duty_out), 249);
        chk("t2_at_target", int'(at_target), 1);

        // 3: reversal through dead time
        target_duty = 8'd50;
        run(88);
        chk("t3_hold50", int'(duty_out), 50);
        target_dir = 1'b1;
        run(56);
        chk("t3_dir", int'(dir_out), 1);
        chk("t3_duty", int'(duty_out), 50);

        // 4: estop mid-ramp
        target_duty = 8'd100;
        runUntilDuty(70, 100, "t4_reach70");
        estop = 1'b1;
        cyc();
        chk("t4_estop_duty", int'(duty_out), 0);
        chk("t4_estop_busy", int'(busy), 1);
        run(6);
        estop = 1'b0;
        run(84);
        chk("t4_resume", int'(duty_out), 100);

        // 5: partial step down, then disable
        target_duty = 8'd95;
        run(12);
        chk("t5_partial", int'(duty_out), 95);
        enable = 1'b0;
        run(48);
        chk("t5_off_duty", int'(duty_out), 0);
        chk("t5_off_busy", int'(busy), 0);

        // 6: asynchronous reset mid-ramp
        enable = 1'b1; target_duty = 8'd100;
        runUntilDuty(60, 100, "t6_reach60");
        #2 reset = 1'b1;
        #1;
        chk("t6_async_duty", int'(duty_out), 0);
        chk("t6_async_dir", int'(dir_out), 0);
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_at", int'(at_target), 0);
        cyc();
        reset = 1'b0;
        run(3);
        chk("t6_no_tick_yet", int'(busy), 0);
        cyc();
        chk("t6_first_tick", int'(busy), 1);
        run(4);
        chk("t6_first_step", int'(duty_out), 10);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) target_duty = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 39) == 0) target_dir = ~target_dir;
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if (estop) estop = ($urandom_range(0, 5) != 0);
            else estop = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
